// File: rtl/matrix_arbiter_if.sv
// matrix_arbiter_if: request/grant/read-back bundle between two requesters and the matrix arbiter
// Signals:
//   req0/req1     request from requester 0/1
//   op0/op1       operation (00 read, 01 set, 10 clear, 11 toggle)
//   x0/y0, x1/y1  cell column/row, cell index = {y,x}
//   lock0/lock1   keep ownership after this op
//   flush         synchronous clear of the whole matrix
//   gnt0/gnt1     combinational grants
//   rdata/rvalid/rid  registered read result, its qualifier and originating requester
//   ones          registered count of set cells
//   owner_busy    a requester currently holds locked ownership
// Modports: slave = arbiter side, master = requester side.
interface matrix_arbiter_if;
    logic       req0, req1;
    logic [1:0] op0, op1;
    logic [1:0] x0, y0, x1, y1;
    logic       lock0, lock1;
    logic       flush;
    logic       gnt0, gnt1;
    logic       rdata, rvalid, rid;
    logic [4:0] ones;
    logic       owner_busy;
    modport slave (
        input  req0, req1, op0, op1, x0, y0, x1, y1, lock0, lock1, flush,
        output gnt0, gnt1, rdata, rvalid, rid, ones, owner_busy
    );
    modport master (
        output req0, req1, op0, op1, x0, y0, x1, y1, lock0, lock1, flush,
        input  gnt0, gnt1, rdata, rvalid, rid, ones, owner_busy
    );
endinterface

// File: rtl/matrix_arbiter.sv
// matrix_arbiter: two-requester round-robin arbiter with burst locking over a 16-cell bit matrix
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  matrix_arbiter_if.slave (requests/ops in, grants/read data/population count out)
// Parameter MAX_BURST (1..15): committed ops a locked owner may issue before ownership ends.
module matrix_arbiter #(
    parameter int MAX_BURST = 4
) (
    input  logic            clk,
    input  logic            rst,
    matrix_arbiter_if.slave bus
);
    typedef enum logic [1:0] {ARB, OWN0, OWN1} state_t;
    localparam logic [3:0] LP_MAX = 4'(MAX_BURST);
    state_t      r_state, w_state_nx;
    logic        r_ptr, w_ptr_nx;
    logic [3:0]  r_burst, w_burst_nx, w_burst_inc;
    logic [15:0] r_cells, w_cells_nx;
    logic [4:0]  r_ones, w_ones_nx;
    logic        r_rdata, r_rid, r_rvalid;
    logic        w_gnt0, w_gnt1, w_commit, w_id, w_lock, w_cell, w_new, w_read;
    logic [1:0]  w_op;
    logic [3:0]  w_addr;
    // Grants look only at req, flush, state and pointer; r_ptr=1 favours requester 1.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!rst && !bus.flush) begin
            case (r_state)
                OWN0:    w_gnt0 = bus.req0;
                OWN1:    w_gnt1 = bus.req1;
                default: begin
                    w_gnt0 = bus.req0 && !(bus.req1 && r_ptr);
                    w_gnt1 = bus.req1 && !(bus.req0 && !r_ptr);
                end
            endcase
        end
    end
    assign w_commit    = w_gnt0 | w_gnt1;
    assign w_id        = w_gnt1;
    assign w_op        = w_id ? bus.op1 : bus.op0;
    assign w_addr      = w_id ? {bus.y1, bus.x1} : {bus.y0, bus.x0};
    assign w_lock      = w_id ? bus.lock1 : bus.lock0;
    assign w_cell      = r_cells[w_addr];
    assign w_read      = w_commit && (w_op == 2'b00);
    assign w_new       = w_op[1] ? (w_op[0] ? ~w_cell : 1'b0) : (w_op[0] ? 1'b1 : w_cell);
    assign w_burst_inc = r_burst + 4'd1;
    // Population count tracks the single cell change of each commit instead of recounting.
    always_comb begin
        w_cells_nx = r_cells;
        w_ones_nx  = r_ones;
        if (bus.flush) begin
            w_cells_nx = '0;
            w_ones_nx  = '0;
        end else if (w_commit) begin
            w_cells_nx[w_addr] = w_new;
            w_ones_nx = r_ones + 5'(w_new & ~w_cell) - 5'(w_cell & ~w_new);
        end
    end
    always_comb begin
        w_state_nx = r_state;
        w_ptr_nx   = r_ptr;
        w_burst_nx = r_burst;
        if (bus.flush) begin
            w_state_nx = ARB;
            w_burst_nx = '0;
        end else begin
            case (r_state)
                ARB: begin
                    if (w_commit) begin
                        w_ptr_nx = ~w_id;
                        if (w_lock && LP_MAX > 4'd1) begin
                            w_state_nx = w_id ? OWN1 : OWN0;
                            w_burst_nx = 4'd1;
                        end
                    end
                end
                default: begin
                    // Without flush the owner is granted whenever it requests, so no commit means it let go.
                    if (!w_commit || !w_lock || w_burst_inc >= LP_MAX) begin
                        w_state_nx = ARB;
                        w_ptr_nx   = (r_state == OWN0);
                        w_burst_nx = '0;
                    end else begin
                        w_burst_nx = w_burst_inc;
                    end
                end
            endcase
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ARB;
            r_ptr    <= 1'b0;
            r_burst  <= '0;
            r_cells  <= '0;
            r_ones   <= '0;
            r_rdata  <= 1'b0;
            r_rid    <= 1'b0;
            r_rvalid <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_ptr    <= w_ptr_nx;
            r_burst  <= w_burst_nx;
            r_cells  <= w_cells_nx;
            r_ones   <= w_ones_nx;
            r_rvalid <= w_read;
            if (w_read) begin
                r_rdata <= w_cell;
                r_rid   <= w_id;
            end
        end
    end
    assign bus.gnt0       = w_gnt0;
    assign bus.gnt1       = w_gnt1;
    assign bus.rdata      = r_rdata;
    assign bus.rvalid     = r_rvalid;
    assign bus.rid        = r_rid;
    assign bus.ones       = r_ones;
    assign bus.owner_busy = (r_state != ARB);
endmodule

// File: tb/tb_matrix_arbiter.sv
// tb_matrix_arbiter: directed plus randomized scoreboard bench for matrix_arbiter
module tb_matrix_arbiter;
    localparam int MAX_BURST = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    matrix_arbiter_if bus();
    matrix_arbiter #(.MAX_BURST(MAX_BURST)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    typedef struct { int due; bit id; bit data; } rd_t;
    rd_t       exp_q[$];
    int        n_cmp = 0;
    int        n_bad = 0;
    int        cyc = 0;
    bit [15:0] m_cells = '0;
    int        m_ones = 0;
    int        m_own = -1;
    int        m_burst = 0;
    int        m_fav = 0;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask
    // Read results are expected exactly one cycle after their commit edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            chk("rvalid", int'(bus.rvalid), 1);
            chk("rdata", int'(bus.rdata), int'(exp_q[0].data));
            chk("rid", int'(bus.rid), int'(exp_q[0].id));
            void'(exp_q.pop_front());
        end else begin
            chk("rvalid_idle", int'(bus.rvalid), 0);
        end
    end
    task automatic model_reset();
        m_cells = '0;
        m_ones  = 0;
        m_own   = -1;
        m_burst = 0;
        m_fav   = 0;
        exp_q.delete();
    endtask
    // One clock of stimulus: check registered outputs, drive, check grants, advance the model.
    task automatic cycle(input bit q0, input bit q1, input bit [1:0] o0, input bit [1:0] o1,
                         input bit [3:0] a0, input bit [3:0] a1, input bit k0, input bit k1, input bit f);
        bit e0, e1, n, lk, old;
        bit [1:0] op;
        bit [3:0] a;
        @(negedge clk);
        chk("ones", int'(bus.ones), m_ones);
        chk("owner_busy", int'(bus.owner_busy), int'(m_own >= 0));
        bus.req0 = q0; bus.req1 = q1; bus.op0 = o0; bus.op1 = o1;
        bus.x0 = a0[1:0]; bus.y0 = a0[3:2]; bus.x1 = a1[1:0]; bus.y1 = a1[3:2];
        bus.lock0 = k0; bus.lock1 = k1; bus.flush = f;
        #1;
        e0 = 1'b0;
        e1 = 1'b0;
        if (!f) begin
            if (m_own == 0) e0 = q0;
            else if (m_own == 1) e1 = q1;
            else if (q0 && q1) begin
                e0 = (m_fav == 0);
                e1 = (m_fav == 1);
            end else begin
                e0 = q0;
                e1 = q1;
            end
        end
        chk("gnt0", int'(bus.gnt0), int'(e0));
        chk("gnt1", int'(bus.gnt1), int'(e1));
        if (f) begin
            m_cells = '0;
            m_own   = -1;
            m_burst = 0;
        end else if (e0 || e1) begin
            n   = e1;
            op  = n ? o1 : o0;
            a   = n ? a1 : a0;
            lk  = n ? k1 : k0;
            old = m_cells[a];
            case (op)
                2'd0:    exp_q.push_back(rd_t'{cyc + 1, n, old});
                2'd1:    m_cells[a] = 1'b1;
                2'd2:    m_cells[a] = 1'b0;
                default: m_cells[a] = !old;
            endcase
            if (m_own < 0) begin
                m_fav = n ? 0 : 1;
                if (lk && MAX_BURST > 1) begin
                    m_own   = int'(n);
                    m_burst = 1;
                end
            end else begin
                m_burst++;
                if (!lk || m_burst >= MAX_BURST) begin
                    m_fav   = n ? 0 : 1;
                    m_own   = -1;
                    m_burst = 0;
                end
            end
        end else if (m_own >= 0) begin
            m_fav   = 1 - m_own;
            m_own   = -1;
            m_burst = 0;
        end
        m_ones = $countones(m_cells);
    endtask
    task automatic idle();
        cycle(0, 0, 2'd0, 2'd0, 4'd0, 4'd0, 0, 0, 0);
    endtask
    // Asynchronous reset asserted mid-cycle, after the edge that may have committed a read.
    task automatic do_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        bus.req0 = 1'b1; bus.req1 = 1'b1; bus.flush = 1'b0;
        #1;
        chk("rst_gnt0", int'(bus.gnt0), 0);
        chk("rst_gnt1", int'(bus.gnt1), 0);
        chk("rst_ones", int'(bus.ones), 0);
        chk("rst_busy", int'(bus.owner_busy), 0);
        chk("rst_rvalid", int'(bus.rvalid), 0);
        model_reset();
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end
    initial begin
        int seq[6];
        bit [1:0] ops[6];
        seq = '{1, 0, 1, 1, 0, 0};
        ops = '{2'd3, 2'd3, 2'd1, 2'd1, 2'd2, 2'd2};
        bus.req0 = 1'b1; bus.req1 = 1'b1; bus.op0 = '0; bus.op1 = '0;
        bus.x0 = '0; bus.y0 = '0; bus.x1 = '0; bus.y1 = '0;
        bus.lock0 = 1'b0; bus.lock1 = 1'b0; bus.flush = 1'b0;
        repeat (2) @(negedge clk);
        chk("init_gnt0", int'(bus.gnt0), 0);
        chk("init_gnt1", int'(bus.gnt1), 0);
        chk("init_ones", int'(bus.ones), 0);
        chk("init_rvalid", int'(bus.rvalid), 0);
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        rst = 1'b0;
        model_reset();
        // Both request after reset: requester 0 first, then 1.
        cycle(1, 1, 2'd1, 2'd1, 4'd0, 4'd5, 0, 0, 0);
        cycle(1, 1, 2'd1, 2'd1, 4'd0, 4'd5, 0, 0, 0);
        @(posedge clk);
        #1;
        chk("pair_ones", int'(bus.ones), 2);
        cycle(1, 0, 2'd0, 2'd0, 4'd0, 4'd0, 0, 0, 0);
        cycle(0, 1, 2'd0, 2'd0, 4'd0, 4'd5, 0, 0, 0);
        // Locked burst of MAX_BURST ops while the other side keeps requesting.
        repeat (5) cycle(1, 1, 2'd0, 2'd0, 4'd1, 4'd2, 1, 0, 0);
        idle();
        // Set cell 15, read 15 and 14 from requester 1.
        cycle(1, 0, 2'd1, 2'd0, 4'd15, 4'd0, 0, 0, 0);
        cycle(0, 1, 2'd0, 2'd0, 4'd0, 4'd15, 0, 0, 0);
        cycle(0, 1, 2'd0, 2'd0, 4'd0, 4'd14, 0, 0, 0);
        idle();
        // Toggle/set/clear sequence on cell 3 from an empty matrix.
        cycle(1, 1, 2'd1, 2'd1, 4'd0, 4'd0, 0, 0, 1);
        for (int k = 0; k < 6; k++) begin
            cycle(1, 0, ops[k], 2'd0, 4'd3, 4'd0, 0, 0, 0);
            @(posedge clk);
            #1;
            chk("seq_ones", int'(bus.ones), seq[k]);
        end
        // Fill the matrix, then flush with both requesting.
        for (int k = 0; k < 16; k++)
            cycle(k % 2 == 0, k % 2 == 1, 2'd1, 2'd1, 4'(k), 4'(k), 0, 0, 0);
        @(posedge clk);
        #1;
        chk("full_ones", int'(bus.ones), 16);
        cycle(1, 1, 2'd1, 2'd1, 4'd0, 4'd0, 0, 0, 1);
        @(posedge clk);
        #1;
        chk("flush_ones", int'(bus.ones), 0);
        for (int k = 0; k < 16; k++) cycle(1, 0, 2'd0, 2'd0, 4'(k), 4'd0, 0, 0, 0);
        idle();
        // Owner drops its request; then reset while requester 1 owns with a read in flight.
        cycle(1, 0, 2'd1, 2'd0, 4'd2, 4'd0, 1, 0, 0);
        cycle(0, 1, 2'd0, 2'd1, 4'd0, 4'd4, 0, 1, 0);
        cycle(1, 1, 2'd0, 2'd1, 4'd0, 4'd4, 0, 1, 0);
        cycle(0, 1, 2'd0, 2'd0, 4'd0, 4'd4, 0, 1, 0);
        do_reset();
        idle();
        idle();
        // Randomized traffic with occasional flushes and resets.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            else cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                       2'($urandom), 2'($urandom), 4'($urandom), 4'($urandom),
                       1'($urandom), 1'($urandom), $urandom_range(0, 24) == 0);
        end
        repeat (3) idle();
        chk("reads_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
